// File: rtl/reg_pkg.sv
// Shared constants and sizing helper for the reg_pipe register chain.
package reg_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline register: a data word plus valid bit with combinational ready chaining.
module reg_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             valid_next
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An empty stage can always take a word; a full one only if it can pass its word on.
    assign ready = !valid_q || down_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign valid_next = valid_d;

endmodule

// File: rtl/reg_pipe.sv
// Valid/ready register pipeline of DEPTH stages with flush and a registered occupancy count.
module reg_pipe
    import reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int CW = count_width(DEPTH);

    logic             stage_valid      [DEPTH];
    logic [WIDTH-1:0] stage_data       [DEPTH];
    logic             stage_ready      [DEPTH+1];
    logic             stage_valid_next [DEPTH];
    logic             feed_valid       [DEPTH];
    logic [WIDTH-1:0] feed_data        [DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign stage_ready[DEPTH] = out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign feed_valid[gi] = in_valid;
                assign feed_data[gi]  = in_data;
            end else begin : g_body
                assign feed_valid[gi] = stage_valid[gi-1];
                assign feed_data[gi]  = stage_data[gi-1];
            end

            reg_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .up_valid   (feed_valid[gi]),
                .up_data    (feed_data[gi]),
                .down_ready (stage_ready[gi+1]),
                .valid      (stage_valid[gi]),
                .data       (stage_data[gi]),
                .ready      (stage_ready[gi]),
                .valid_next (stage_valid_next[gi])
            );
        end
    endgenerate

    // Count tracks the valid bits the stages will hold after this edge.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(stage_valid_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready  = stage_ready[0] && !flush;
    assign out_valid = stage_valid[DEPTH-1] && !flush;
    assign out_data  = stage_data[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe: vector table at DEPTH=3 plus reset and DEPTH=1 sequences.
module tb_reg_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  in_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [7:0]  out_data1;
    logic [0:0]  count1;
    logic        flush1;

    int tests;
    int fails;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    reg_pipe #(.WIDTH(32), .DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .count     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic ordy, input logic fl, input logic [31:0] d,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                       input logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sb[$];
        logic [7:0] nxt;
        logic [7:0] exp_w;
        int popped;

        tests = 0;
        fails = 0;

        // latency and throughput, out_ready=1
        add(1, 1, 0, 32'h11, 1, 0, 32'h0,  2'd1);
        add(1, 1, 0, 32'h22, 1, 0, 32'h0,  2'd2);
        add(1, 1, 0, 32'h33, 1, 0, 32'h0,  2'd3);
        add(1, 1, 0, 32'h44, 1, 1, 32'h11, 2'd3);
        add(0, 1, 0, 32'h0,  1, 1, 32'h22, 2'd2);
        add(0, 1, 0, 32'h0,  1, 1, 32'h33, 2'd1);
        add(0, 1, 0, 32'h0,  1, 1, 32'h44, 2'd0);
        add(0, 1, 0, 32'h0,  1, 0, 32'h0,  2'd0);
        // fill under backpressure, then release
        add(1, 0, 0, 32'hA0, 1, 0, 32'h0,  2'd1);
        add(1, 0, 0, 32'hA1, 1, 0, 32'h0,  2'd2);
        add(1, 0, 0, 32'hA2, 1, 0, 32'h0,  2'd3);
        add(1, 0, 0, 32'hA3, 0, 1, 32'hA0, 2'd3);
        add(1, 1, 0, 32'hA3, 1, 1, 32'hA0, 2'd3);
        add(0, 1, 0, 32'h0,  1, 1, 32'hA1, 2'd2);
        add(0, 1, 0, 32'h0,  1, 1, 32'hA2, 2'd1);
        add(0, 1, 0, 32'h0,  1, 1, 32'hA3, 2'd0);
        // simultaneous full and pop
        add(1, 0, 0, 32'hB0, 1, 0, 32'h0,  2'd1);
        add(1, 0, 0, 32'hB1, 1, 0, 32'h0,  2'd2);
        add(1, 0, 0, 32'hB2, 1, 0, 32'h0,  2'd3);
        add(1, 1, 0, 32'hB3, 1, 1, 32'hB0, 2'd3);
        add(0, 1, 0, 32'h0,  1, 1, 32'hB1, 2'd2);
        add(0, 1, 0, 32'h0,  1, 1, 32'hB2, 2'd1);
        add(0, 1, 0, 32'h0,  1, 1, 32'hB3, 2'd0);
        // flush with two words in flight, one of them in the last stage
        add(1, 1, 0, 32'hD1, 1, 0, 32'h0,  2'd1);
        add(1, 1, 0, 32'hD2, 1, 0, 32'h0,  2'd2);
        add(0, 0, 0, 32'h0,  1, 0, 32'h0,  2'd2);
        add(1, 1, 1, 32'hE0, 0, 0, 32'h0,  2'd0);
        add(0, 1, 0, 32'h0,  1, 0, 32'h0,  2'd0);
        add(0, 1, 0, 32'h0,  1, 0, 32'h0,  2'd0);
        add(0, 1, 0, 32'h0,  1, 0, 32'h0,  2'd0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_count",     {30'd0, count}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;

        foreach (vq[i]) begin
            in_valid  = vq[i].iv;
            out_ready = vq[i].ordy;
            flush     = vq[i].fl;
            in_data   = vq[i].d;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vq[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vq[i].e_ov});
            if (vq[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, vq[i].e_od);
            tick();
            chk($sformatf("v%0d_count", i), {30'd0, count}, {30'd0, vq[i].e_cnt});
            $display("[TB] vec %0d iv=%0b or=%0b fl=%0b d=0x%0h ir=%0b ov=%0b od=0x%0h cnt=%0d",
                     i, vq[i].iv, vq[i].ordy, vq[i].fl, vq[i].d, in_ready, out_valid, out_data, count);
        end
        flush = 1'b0;

        // asynchronous reset between edges with count=2
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hF1; tick();
        in_data = 32'hF2; tick();
        in_valid = 1'b0; tick();
        @(negedge clk);
        chk("ar_pre_count", {30'd0, count}, 32'd2);
        chk("ar_pre_out_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_pre_out_data", out_data, 32'hF1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data",  out_data, 32'd0);
        chk("ar_count",     {30'd0, count}, 32'd0);
        in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        tick();
        chk("ar_hold_count", {30'd0, count}, 32'd0);
        chk("ar_hold_out_valid", {31'd0, out_valid}, 32'd0);
        #2;
        rst = 1'b0;
        in_data = 32'hC5;
        tick();
        in_valid = 1'b0;
        chk("c5_edge1_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("c5_edge2_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("c5_edge3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("c5_edge3_out_data",  out_data, 32'hC5);
        tick();
        chk("c5_drained_count", {30'd0, count}, 32'd0);
        $display("[TB] async reset sequence done, out_valid=%0b count=%0d", out_valid, count);

        // DEPTH=1, alternating out_ready with continuous in_valid
        nxt = 8'h50;
        popped = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid1  = (c < 20);
            out_ready1 = (c >= 20) || (c % 2 == 0);
            in_data1   = nxt;
            @(negedge clk);
            if (c < 20) chk($sformatf("d1_c%0d_in_ready", c), {31'd0, in_ready1}, {31'd0, (c % 2 == 0)});
            if (out_valid1 && out_ready1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("d1_c%0d_unexpected_pop", c), {24'd0, out_data1}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb.pop_front();
                    chk($sformatf("d1_c%0d_order", c), {24'd0, out_data1}, {24'd0, exp_w});
                end
                popped++;
            end
            if (in_valid1 && in_ready1) begin
                sb.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            $display("[TB] d1 cycle %0d iv=%0b ir=%0b ov=%0b or=%0b od=0x%0h", c, in_valid1, in_ready1,
                     out_valid1, out_ready1, out_data1);
            tick();
        end
        chk("d1_popped_total", popped, 32'd10);
        chk("d1_left_over", sb.size(), 32'd0);
        chk("d1_count_empty", {31'd0, count1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
